// File: rtl/uart_pkg.sv
// Shared defaults and drain-FSM encoding for the UART transmit FIFO.
package uart_pkg;

    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned FIFO_ADDR_W = 4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: unreset register-array storage, wrapping pointers, registered count.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              push,
    input  logic [7:0]        push_data,
    input  logic              pop,
    output logic [7:0]        pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_50mhz) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == DepthCnt);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter; a small FSM drains one byte per transmitter handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              tx_busy,
    output logic [7:0]        uart_data,
    output logic              uart_wr_en
);

    drain_state_e state_q;
    drain_state_e state_d;
    logic         pop;
    logic [7:0]   pop_data;
    logic         overflow_q;
    logic         uart_wr_en_q;
    logic [7:0]   uart_data_q;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // The pop happens on the edge that enters StIssue, so the strobe and byte register together.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !tx_busy) begin
                    state_d = StIssue;
                    pop     = 1'b1;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            overflow_q   <= 1'b0;
            uart_wr_en_q <= 1'b0;
            uart_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            overflow_q   <= wr_en && full;
            uart_wr_en_q <= pop;
            if (pop) begin
                uart_data_q <= pop_data;
            end
        end
    end

    assign overflow   = overflow_q;
    assign uart_wr_en = uart_wr_en_q;
    assign uart_data  = uart_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte scoreboard and a simple transmitter busy model.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk_50mhz = 1'b0;
    logic              rst_n     = 1'b1;
    logic              wr_en     = 1'b0;
    logic [7:0]        wr_data   = 8'h00;
    logic              tx_busy   = 1'b0;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        uart_data;
    logic              uart_wr_en;

    int errors      = 0;
    int checks      = 0;
    int strobe_cnt  = 0;
    int ovf_cnt     = 0;
    int busy_cnt    = 0;
    int busy_len    = 10;
    bit busy_model  = 1'b0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_busy    (tx_busy),
        .uart_data  (uart_data),
        .uart_wr_en (uart_wr_en)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter side: scoreboard each strobe, then optionally hold tx_busy for busy_len cycles.
    always @(posedge clk_50mhz) begin
        #1;
        if (overflow) ovf_cnt++;
        if (busy_model && busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (uart_wr_en) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_strobe", {31'b0, uart_wr_en}, 32'd0);
            end else begin
                check("tx_byte_order", {24'b0, uart_data}, {24'b0, exp_q.pop_front()});
            end
            if (busy_model) begin
                busy_cnt = busy_len;
                tx_busy  = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_out);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_out) exp_q.push_back(b);
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy || uart_wr_en) && n < 3000) begin
            step();
            n++;
        end
        repeat (3) step();
        check({tag, "_drain_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s;
        int base_o;
        int sent;
        int n;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #2;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_uart_wr_en", uart_wr_en, 0);
        check("rst_uart_data", uart_data, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single byte latency
        busy_model = 1'b1;
        busy_len   = 10;
        base_s     = strobe_cnt;
        push_byte(8'hA5, 1'b1);
        check("a5_count_after_push", count, 1);
        check("a5_empty_after_push", empty, 0);
        check("a5_no_strobe_yet", uart_wr_en, 0);
        step();
        check("a5_strobe", uart_wr_en, 1);
        check("a5_data", uart_data, 8'hA5);
        check("a5_count_after_pop", count, 0);
        step();
        check("a5_strobe_one_cycle", uart_wr_en, 0);
        wait_drain("a5");
        check("a5_data_held", uart_data, 8'hA5);
        check("a5_strobe_total", strobe_cnt - base_s, 1);

        // Fill with transmitter busy, then overflow
        busy_model = 1'b0;
        tx_busy    = 1'b1;
        base_o     = ovf_cnt;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b1);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        push_byte(8'hEE, 1'b0);
        check("ovf_pulse", overflow, 1);
        check("ovf_count_held", count, 16);
        step();
        check("ovf_pulse_one_cycle", overflow, 0);
        check("ovf_pulse_total", ovf_cnt - base_o, 1);

        // Drain sixteen with busy model
        base_s     = strobe_cnt;
        base_o     = ovf_cnt;
        busy_model = 1'b1;
        tx_busy    = 1'b0;
        wait_drain("drain16");
        check("drain16_strobes", strobe_cnt - base_s, 16);
        check("drain16_empty", empty, 1);

        // Streaming across pointer wrap
        busy_len = 2;
        base_s   = strobe_cnt;
        base_o   = ovf_cnt;
        sent     = 0;
        n        = 0;
        while (sent < 40 && n < 2000) begin
            if (!full) begin
                wr_en   = 1'b1;
                wr_data = 8'h40 + 8'(sent);
                exp_q.push_back(wr_data);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            step();
            n++;
        end
        wr_en = 1'b0;
        wait_drain("wrap");
        check("wrap_strobes", strobe_cnt - base_s, 40);
        check("wrap_no_overflow", ovf_cnt - base_o, 0);
        check("wrap_count", count, 0);

        // Reset while in WAIT_DONE with five bytes queued
        busy_model = 1'b0;
        busy_len   = 10;
        tx_busy    = 1'b0;
        push_byte(8'hC0, 1'b1);
        push_byte(8'hC1, 1'b0);
        tx_busy = 1'b1;
        for (int i = 2; i < 6; i++) push_byte(8'hC0 + 8'(i), 1'b0);
        check("pre_rst_count", count, 5);
        check("pre_rst_no_strobe", uart_wr_en, 0);
        base_s = strobe_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_uart_wr_en", uart_wr_en, 0);
        check("mid_rst_uart_data", uart_data, 8'h00);
        step();
        step();
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        repeat (30) step();
        check("post_rst_no_strobe", strobe_cnt - base_s, 0);
        check("post_rst_empty", empty, 1);

        // Push against full on the same edge as a pop
        tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i), 1'b1);
        check("pp_full", full, 1);
        base_s     = strobe_cnt;
        tx_busy    = 1'b0;
        busy_model = 1'b1;
        push_byte(8'h77, 1'b0);
        check("pp_count", count, 15);
        check("pp_overflow", overflow, 1);
        check("pp_strobe", uart_wr_en, 1);
        check("pp_data", uart_data, 8'h80);
        wait_drain("pp");
        check("pp_strobes", strobe_cnt - base_s, 16);
        check("pp_final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 4: pointer width; SHALL equal log2(DEPTH).
REQ-003 clk_50mhz  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  host push request for wr_data.
REQ-006 wr_data  input  8  byte to queue.
REQ-007 full  output  1  high when count == DEPTH.
REQ-008 empty  output  1  high when count == 0.
REQ-009 count  output  ADDR_W+1  number of bytes held, 0..DEPTH.
REQ-010 overflow  output  1  one-cycle pulse when a push is rejected.
REQ-011 tx_busy  input  1  busy flag from the UART transmitter.
REQ-012 uart_data  output  8  byte presented to the transmitter data_in.
REQ-013 uart_wr_en  output  1  one-cycle write strobe to the transmitter write_enable.

Function
REQ-014 Push: on an edge with wr_en=1 and full=0, the FIFO SHALL store wr_data at the write pointer and increment the write pointer modulo DEPTH.
REQ-015 Push with full=1 SHALL store nothing and SHALL pulse overflow high for the following cycle, even if a pop occurs on the same edge.
REQ-016 Pop SHALL occur only on the edge that enters ISSUE; the read pointer SHALL then increment modulo DEPTH.
REQ-017 Simultaneous accepted push and pop SHALL leave count unchanged.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of bytes.
REQ-019 Bytes SHALL leave the block in push order.
REQ-020 The drain FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE -> ISSUE when empty=0 and tx_busy=0; otherwise the FSM SHALL stay in IDLE.
REQ-022 In ISSUE, uart_wr_en=1 and uart_data=popped byte, both registered; the FSM SHALL go to WAIT_BUSY unconditionally after one cycle.
REQ-023 WAIT_BUSY -> WAIT_DONE when tx_busy=1.
REQ-024 WAIT_DONE -> IDLE when tx_busy=0.
REQ-025 uart_wr_en SHALL be high only in ISSUE, and for exactly one cycle per byte.
REQ-026 uart_data SHALL hold its last value outside ISSUE.
REQ-027 Latency: after a push accepted on edge N into an empty FIFO with tx_busy=0, uart_wr_en SHALL be high between edges N+1 and N+2.
REQ-028 full, empty and count SHALL reflect the state after each edge; they SHALL be registered or derived from registered pointers only.

Reset
REQ-029 While rst_n=0, with no clock edge required: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, uart_wr_en=0, uart_data=8'h00.
REQ-030 Reset asserted mid-transfer SHALL discard all queued bytes; storage contents need not be cleared.
REQ-031 Reset deassertion SHALL be synchronised externally; the first edge after release SHALL behave as a normal IDLE cycle.

Structure
REQ-032 A shared package uart_pkg SHALL hold the default DEPTH and ADDR_W and the drain-FSM state encoding (2-bit typedef).
REQ-033 Storage and pointers SHALL live in one sub-module, sync_fifo (push/pop/full/empty/count); the drain FSM SHALL live in uart_tx_fifo.
REQ-034 Storage SHALL be a plain register array without reset, inferable as distributed RAM.

Verification
REQ-035 Push 8'hA5 into an empty FIFO with tx_busy=0 -> uart_wr_en pulses once, one edge later, with uart_data=8'hA5; count returns to 0.
REQ-036 Push 16 bytes 0x00..0x0F with tx_busy held 1 -> full=1 and count=16; a 17th push gives an overflow pulse and count stays 16.
REQ-037 Release tx_busy; model busy as 1 for 10 cycles after each strobe -> exactly 16 strobes, carrying 0x00..0x0F in order.
REQ-038 Push on every edge while draining across pointer wrap (40 bytes) -> output sequence equals input sequence and no overflow occurs.
REQ-039 Assert rst_n=0 in WAIT_DONE with count=5 -> outputs take the REQ-029 values immediately and no strobe occurs after release.
REQ-040 Push and pop on the same edge with count=16 -> push rejected with an overflow pulse; count becomes 15.
